// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IWB     = 4'd10,
    S_JEX     = 4'd11,
    S_ORIEX   = 4'd12,
    S_BNEEX   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_t;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU function decoder: maps the controller's aluop and the R-type funct field
// to the 3-bit ALU operation.
module mc_aludec import mc_pkg::*; (
  input  aluop_t      aluop_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_OR:  alucontrol_o = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore main controller for the multicycle MIPS datapath: sequences fetch,
// decode, execute, memory and writeback, and forms the PC enable.
module mc_controller import mc_pkg::*; #(
  parameter bit EXT_OPS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       zeroext,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcwrite, branch, bne_br;
  logic   irwrite_raw, memwrite_raw, regwrite_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = EXT_OPS ? S_BNEEX : S_FETCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = EXT_OPS ? S_ORIEX : S_FETCH;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD:          state_d = S_MEMWB;
      S_RTYPEEX:        state_d = S_RTYPEWB;
      S_ADDIEX, S_ORIEX: state_d = S_IWB;
      default:          state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bne_br       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    zeroext      = 1'b0;
    aluop        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = (state_q == S_BEQEX);
        bne_br  = (state_q == S_BNEEX);
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_OR;
        zeroext = 1'b1;
      end
      S_IWB: regwrite_raw = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  // State already reads FETCH during reset; only the write strobes need masking.
  assign pcen     = ~reset & (pcwrite | (branch & zero) | (bne_br & ~zero));
  assign irwrite  = ~reset & irwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: EXT_OPS=1 and EXT_OPS=0 instances
// checked every cycle against an instruction-path model, plus literal checks.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  bit         rand_zero = 1'b0;

  logic [1:0] pcen_w, memwrite_w, irwrite_w, regwrite_w, iord_w, memtoreg_w;
  logic [1:0] regdst_w, alusrca_w, zeroext_w;
  logic [1:0] alusrcb_w [2];
  logic [1:0] pcsrc_w [2];
  logic [2:0] alucontrol_w [2];
  logic [3:0] state_w [2];
  logic [19:0] obs [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mc_controller #(.EXT_OPS(1'b1)) dut_ext (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen_w[0]), .memwrite(memwrite_w[0]), .irwrite(irwrite_w[0]),
    .regwrite(regwrite_w[0]), .iord(iord_w[0]), .memtoreg(memtoreg_w[0]),
    .regdst(regdst_w[0]), .alusrca(alusrca_w[0]), .alusrcb(alusrcb_w[0]),
    .pcsrc(pcsrc_w[0]), .zeroext(zeroext_w[0]), .alucontrol(alucontrol_w[0]),
    .state(state_w[0])
  );

  mc_controller #(.EXT_OPS(1'b0)) dut_base (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen_w[1]), .memwrite(memwrite_w[1]), .irwrite(irwrite_w[1]),
    .regwrite(regwrite_w[1]), .iord(iord_w[1]), .memtoreg(memtoreg_w[1]),
    .regdst(regdst_w[1]), .alusrca(alusrca_w[1]), .alusrcb(alusrcb_w[1]),
    .pcsrc(pcsrc_w[1]), .zeroext(zeroext_w[1]), .alucontrol(alucontrol_w[1]),
    .state(state_w[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {pcen_w[g], memwrite_w[g], irwrite_w[g], regwrite_w[g],
                     iord_w[g], memtoreg_w[g], regdst_w[g], alusrca_w[g],
                     alusrcb_w[g], pcsrc_w[g], zeroext_w[g], alucontrol_w[g],
                     state_w[g]};
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
  endtask

  task automatic chkv(input string nm, input logic [19:0] got, input logic [19:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %05h, expected %05h (t=%0t)", nm, got, want, $time);
  endtask

  // ---------------- reference model: per-opcode state path ----------------
  function automatic int path_len(input logic [5:0] o, input bit ext);
    case (o)
      6'b100011:                       return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b001101:                       return ext ? 4 : 2;
      6'b000100, 6'b000010:            return 3;
      6'b000101:                       return ext ? 3 : 2;
      default:                         return 2;
    endcase
  endfunction

  function automatic int path_state(input logic [5:0] o, input int i);
    if (i == 1) return 1;
    case (o)
      6'b100011: return (i == 2) ? 2 : (i == 3) ? 3 : 4;
      6'b101011: return (i == 2) ? 2 : 5;
      6'b000000: return (i == 2) ? 6 : 7;
      6'b000100: return 8;
      6'b000101: return 13;
      6'b001000: return (i == 2) ? 9 : 10;
      6'b001101: return (i == 2) ? 12 : 10;
      6'b000010: return 11;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [19:0] expect_vec(input int s, input logic z,
                                             input logic [5:0] f, input logic rst);
    logic pcw = 1'b0, br = 1'b0, bn = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0;
    logic io = 1'b0, m2r = 1'b0, rd = 1'b0, asa = 1'b0, ze = 1'b0, pce;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] ac = 3'b010;
    case (s)
      0:  begin irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  io = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6: begin
        asa = 1'b1;
        case (f)
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   ac = 3'b010;
        endcase
      end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; ac = 3'b110; pcs = 2'b01; br = 1'b1; end
      13: begin asa = 1'b1; ac = 3'b110; pcs = 2'b01; bn = 1'b1; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      12: begin asa = 1'b1; asb = 2'b10; ac = 3'b001; ze = 1'b1; end
      10: rw = 1'b1;
      11: begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    pce = ~rst & (pcw | (br & z) | (bn & ~z));
    return {pce, mw & ~rst, irw & ~rst, rw & ~rst, io, m2r, rd, asa,
            asb, pcs, ze, ac, 4'(s)};
  endfunction

  int         pos [2] = '{0, 0};
  logic [5:0] op_lat [2];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) pos[k] = 0;
      else begin
        if (pos[k] == 0) op_lat[k] = op;
        pos[k] = pos[k] + 1;
        if (pos[k] >= path_len(op_lat[k], k == 0)) pos[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int s;
      s = (pos[k] == 0) ? 0 : path_state(op_lat[k], pos[k]);
      chkv(k == 0 ? "cycle_ext" : "cycle_base", obs[k], expect_vec(s, zero, funct, reset));
    end
  end

  always @(posedge clk) begin
    if (rand_zero) begin
      #2;
      zero = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    int n = 0;
    while (!(pos[0] == 0 && pos[1] == 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      $display("FAIL align: instances never both reached FETCH, pos %0d/%0d", pos[0], pos[1]);
    end
    #1;
    op = o;
    funct = f;
    if (!rand_zero) zero = z;
  endtask

  task automatic step_chk(input string nm, input int k, input int want);
    @(negedge clk);
    chk(nm, int'(state_w[k]), want);
  endtask

  int lw_seq [6] = '{0, 1, 2, 3, 4, 0};
  int sw_seq [4] = '{1, 2, 5, 0};
  logic [5:0] op_tab [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                              6'b001000, 6'b001101, 6'b000010, 6'b111111, 6'b010101};
  logic [5:0] fn_tab [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(state_w[0]), 0);
    chk("rst_irwrite", int'(irwrite_w[0]), 0);
    chk("rst_pcen", int'(pcen_w[0]), 0);
    @(posedge clk);
    #2 reset = 1'b0;

    // lw from reset
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lw_seq", int'(state_w[0]), lw_seq[i]);
      if (i == 0) chk("fetch_irwrite", int'(irwrite_w[0]), 1);
      if (i == 3) chk("lw_iord", int'(iord_w[0]), 1);
      if (i == 4) chk("lw_wb", int'({regwrite_w[0], memtoreg_w[0]}), 3);
    end

    start_instr(6'b101011, 6'b100000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sw_seq", int'(state_w[0]), sw_seq[i]);
      chk("sw_memwrite", int'(memwrite_w[0]), (i == 2) ? 1 : 0);
    end

    start_instr(6'b000100, 6'b100000, 1'b1);
    step_chk("beq_dec", 0, 1);
    step_chk("beq_ex", 0, 8);
    chk("beq_z1_pcen", int'(pcen_w[0]), 1);
    chk("beq_pcsrc", int'(pcsrc_w[0]), 1);
    step_chk("beq_done", 0, 0);

    start_instr(6'b000100, 6'b100000, 1'b0);
    step_chk("beq_dec", 0, 1);
    step_chk("beq_ex", 0, 8);
    chk("beq_z0_pcen", int'(pcen_w[0]), 0);
    step_chk("beq_done", 0, 0);

    start_instr(6'b000101, 6'b100000, 1'b1);
    step_chk("bne_dec", 0, 1);
    step_chk("bne_ex", 0, 13);
    chk("bne_z1_pcen", int'(pcen_w[0]), 0);
    chk("bne_base_nop", int'(state_w[1]), 0);
    step_chk("bne_done", 0, 0);

    start_instr(6'b000101, 6'b100000, 1'b0);
    step_chk("bne_dec", 0, 1);
    step_chk("bne_ex", 0, 13);
    chk("bne_z0_pcen", int'(pcen_w[0]), 1);
    step_chk("bne_done", 0, 0);

    start_instr(6'b000000, 6'b101010, 1'b0);
    step_chk("r_dec", 0, 1);
    step_chk("r_ex", 0, 6);
    chk("slt_alucontrol", int'(alucontrol_w[0]), 7);
    step_chk("r_wb", 0, 7);
    chk("r_wb_ctl", int'({regdst_w[0], regwrite_w[0]}), 3);
    step_chk("r_done", 0, 0);

    start_instr(6'b001101, 6'b100000, 1'b0);
    step_chk("ori_dec", 0, 1);
    step_chk("ori_ex", 0, 12);
    chk("ori_alucontrol", int'(alucontrol_w[0]), 1);
    chk("ori_zeroext", int'(zeroext_w[0]), 1);
    chk("ori_base_nop", int'(state_w[1]), 0);
    step_chk("ori_wb", 0, 10);
    step_chk("ori_done", 0, 0);

    start_instr(6'b111111, 6'b100000, 1'b0);
    step_chk("ill_dec", 0, 1);
    step_chk("ill_done", 0, 0);
    step_chk("ill_dec_base", 1, 1);
    chk("ill_no_we", int'({memwrite_w[0], regwrite_w[0]}), 0);

    // asynchronous reset in the middle of MEMRD
    start_instr(6'b100011, 6'b100000, 1'b0);
    step_chk("mr_dec", 0, 1);
    step_chk("mr_adr", 0, 2);
    step_chk("mr_rd", 0, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_state_ext", int'(state_w[0]), 0);
    chk("async_state_base", int'(state_w[1]), 0);
    chk("async_we_ext", int'({pcen_w[0], irwrite_w[0], memwrite_w[0], regwrite_w[0]}), 0);
    chk("async_we_base", int'({pcen_w[1], irwrite_w[1], memwrite_w[1], regwrite_w[1]}), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    step_chk("post_rst_fetch", 0, 0);
    chk("post_rst_irwrite", int'(irwrite_w[0]), 1);
    step_chk("post_rst_dec", 0, 1);

    // randomized instruction stream
    rand_zero = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      start_instr(op_tab[$urandom_range(0, 9)], fn_tab[$urandom_range(0, 5)], 1'b0);
    end
    rand_zero = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Main control unit for the multicycle MIPS processor. It is a Moore FSM that sequences the shared datapath (single memory, single ALU, IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback steps. It also decodes the ALU function and produces the PC enable. It sits inside the processor between the instruction register (op/funct fields), the ALU zero flag and the datapath mux and enable controls. It exports its state for bench visibility.

Parameters:
EXT_OPS, 1, 1 = bne and ori supported; 0 = their opcodes are treated as illegal.

Ports:
clk  input  1  processor clock, rising edge
reset  input  1  asynchronous, active-high; forces state to FETCH
op  input  6  instr[31:26]
funct  input  6  instr[5:0]
zero  input  1  ALU zero flag (from ALUOut compare in branch step)
pcen  output  1  PC register enable
memwrite  output  1  memory write enable
irwrite  output  1  instruction register enable
regwrite  output  1  register file write enable
iord  output  1  memory address select, 0=PC, 1=ALUOut
memtoreg  output  1  writeback select, 1=data register
regdst  output  1  write register select, 1=rd, 0=rt
alusrca  output  1  ALU A select, 0=PC, 1=A
alusrcb  output  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
zeroext  output  1  immediate is zero-extended (ori)
alucontrol  output  3  ALU operation
state  output  4  current state encoding

Behaviour:
- State encoding (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IWB 10, JEX 11, ORIEX 12, BNEEX 13. Codes 14 and 15 are unused and go to FETCH next cycle.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, j 000010.
- Transitions:
  - FETCH→DECODE.
  - DECODE dispatches: lw/sw→MEMADR; R→RTYPEEX; beq→BEQEX; bne→BNEEX; addi→ADDIEX; ori→ORIEX; j→JEX; any other opcode→FETCH (NOP).
  - MEMADR: lw→MEMRD, sw→MEMWR.
  - MEMRD→MEMWB. RTYPEEX→RTYPEWB. ADDIEX, ORIEX→IWB.
  - MEMWB, MEMWR, RTYPEWB, IWB, BEQEX, BNEEX, JEX→FETCH.
- Moore outputs are a function of state only. Any signal not listed for a state is 0.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - BNEEX: same as BEQEX but bne=1 and branch=0.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ORIEX: alusrca=1, alusrcb=10, aluop=11, zeroext=1.
  - IWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero) | (bne & ~zero). This is combinational within the cycle, so zero must be valid in BEQEX/BNEEX.
- ALU decode (aluop, internal 2 bits):
  - aluop 00→010 (add), 01→110 (sub), 11→001 (or).
  - aluop 10 uses funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other funct→010.
- Reset:
  - Asynchronous; state=FETCH immediately on assertion, including mid-instruction.
  - While reset=1, pcen, irwrite, memwrite and regwrite are forced to 0. The other outputs show FETCH values.
  - The first FETCH executes on the first rising edge after deassertion.
- Latency in cycles, counting FETCH: lw 5; sw, R, addi, ori 4; beq, bne, j 3.
- EXT_OPS=0: bne and ori opcodes take DECODE→FETCH. States 12 and 13 are unreachable.

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit, codes above)
  - opcode localparams
  - aluop codes
  - alucontrol codes
- Sub-module mc_aludec (combinational: aluop, funct → alucontrol).
- The FSM and output decode stay in mc_controller.

Test Plan:
- Reset held 2 cycles then released, op=100011 (lw): state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
- op=101011 (sw): states 0,1,2,5,0. memwrite=1 only in state 5, never in any other cycle.
- op=000100 (beq): zero=1 in state 8 gives pcen=1, pcsrc=01. Rerun with zero=0: pcen=0. Repeat for bne (state 13) with inverted outcome.
- op=000000, funct=101010: alucontrol=111 in state 6, regdst=1 and regwrite=1 in state 7. op=001101 (ori): state 12 with alucontrol=001 and zeroext=1, then state 10.
- Reset asserted asynchronously mid-cycle in state 3: state=0 before the next edge, all four write enables 0 while reset=1.
- op=111111 (illegal): states 0,1,0, no write enable asserted after FETCH. With EXT_OPS=0, op=000101 also gives 0,1,0.
